// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller for a 32x16, 1/8-scan panel; all state advances on the external tick.
// Optional build macro MATRIX_BLANK_EXTEND_EN stretches BLANK to BLANK_TICKS ticks.
module hub75_scan_ctrl #(
  parameter int unsigned COLS        = 32,
  parameter int unsigned SCAN_ROWS   = 8,
  parameter int unsigned ON_TICKS    = 64,
  parameter int unsigned BLANK_TICKS = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          tick,
  output logic [$clog2(SCAN_ROWS)+$clog2(COLS)-1:0]     fb_addr,
  input  logic [2:0]                                    fb_rgb_top,
  input  logic [2:0]                                    fb_rgb_bot,
  output logic                                          r1,
  output logic                                          g1,
  output logic                                          b1,
  output logic                                          r2,
  output logic                                          g2,
  output logic                                          b2,
  output logic [$clog2(SCAN_ROWS)-1:0]                  row_addr,
  output logic                                          sclk,
  output logic                                          lat,
  output logic                                          oe_n,
  output logic                                          frame_done
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(SCAN_ROWS);
  localparam int unsigned ON_W  = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);
  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_TICKS - 1);

  if (ON_TICKS < 1 || BLANK_TICKS < 1) begin : g_bad_params
    $error("hub75_scan_ctrl: ON_TICKS and BLANK_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  state_e                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d, col_inc;
  logic [ROW_W-1:0]       row_q, row_d, row_nxt;
  logic                   phase_q, phase_d;
  logic [ON_W-1:0]        on_cnt_q, on_cnt_d;
  logic [ROW_W+COL_W-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]             top_q, top_d;
  logic [2:0]             bot_q, bot_d;
  logic [ROW_W-1:0]       row_addr_q, row_addr_d;
  logic                   sclk_q, sclk_d;
  logic                   lat_q, lat_d;
  logic                   oe_n_q, oe_n_d;
  logic                   frame_done_q, frame_done_d;
  logic                   shown_q, shown_d;
  logic                   blank_done;

`ifdef MATRIX_BLANK_EXTEND_EN
  localparam int unsigned       BLK_W    = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLANK_TICKS - 1);

  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;

  assign blank_done = (blank_cnt_q == BLK_LAST);

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (tick && state_q == ST_BLANK) begin
      blank_cnt_d = blank_done ? '0 : blank_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) blank_cnt_q <= '0;
    else     blank_cnt_q <= blank_cnt_d;
  end
`else
  assign blank_done = 1'b1;
`endif

  assign col_inc = col_q + 1'b1;
  assign row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    phase_d      = phase_q;
    on_cnt_d     = on_cnt_q;
    fb_addr_d    = fb_addr_q;
    top_d        = top_q;
    bot_d        = bot_q;
    row_addr_d   = row_addr_q;
    sclk_d       = sclk_q;
    lat_d        = lat_q;
    oe_n_d       = oe_n_q;
    shown_d      = shown_q;
    frame_done_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_SHIFT: begin
          oe_n_d = ~shown_q;
          if (!phase_q) begin
            sclk_d  = 1'b0;
            top_d   = fb_rgb_top;
            bot_d   = fb_rgb_bot;
            phase_d = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            phase_d = 1'b0;
            if (col_q != COL_LAST) begin
              col_d     = col_inc;
              fb_addr_d = {row_q, col_inc};
            end else begin
              // Prefetch pixel 0 of the next row so its data is ready for the next SHIFT.
              col_d     = '0;
              fb_addr_d = {row_nxt, {COL_W{1'b0}}};
              state_d   = ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          oe_n_d = 1'b1;
          sclk_d = 1'b0;
          if (blank_done) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          lat_d        = 1'b1;
          row_addr_d   = row_q;
          shown_d      = 1'b1;
          frame_done_d = (row_q == ROW_LAST);
          state_d      = ST_DISPLAY;
        end
        ST_DISPLAY: begin
          lat_d  = 1'b0;
          oe_n_d = 1'b0;
          if (on_cnt_q == ON_LAST) begin
            on_cnt_d = '0;
            row_d    = row_nxt;
            state_d  = ST_SHIFT;
          end else begin
            on_cnt_d = on_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments; reset is synchronous and covers every register.
    if (rst) begin
      state_q      <= ST_SHIFT;
      col_q        <= '0;
      row_q        <= '0;
      phase_q      <= 1'b0;
      on_cnt_q     <= '0;
      fb_addr_q    <= '0;
      top_q        <= '0;
      bot_q        <= '0;
      row_addr_q   <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      shown_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      phase_q      <= phase_d;
      on_cnt_q     <= on_cnt_d;
      fb_addr_q    <= fb_addr_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      row_addr_q   <= row_addr_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
      shown_q      <= shown_d;
    end
  end

  assign fb_addr      = fb_addr_q;
  assign {r1, g1, b1} = top_q;
  assign {r2, g2, b2} = bot_q;
  assign row_addr     = row_addr_q;
  assign sclk         = sclk_q;
  assign lat          = lat_q;
  assign oe_n         = oe_n_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: tick-level reference model via scoreboard queue,
// a checkpoint table for scan boundaries, and hand-written reset/frame sequences.
module tb_hub75_scan_ctrl;

  localparam int C  = 32;
  localparam int R  = 8;
  localparam int ON = 64;
`ifdef MATRIX_BLANK_EXTEND_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif
  localparam int P     = 2*C + BL + 1 + ON;
  localparam int LAT_T = 2*C + BL;
  localparam int NCP   = 15;

  typedef struct packed {
    logic [7:0] fb_addr;
    logic [2:0] top;
    logic [2:0] bot;
    logic [2:0] row_addr;
    logic       sclk;
    logic       lat;
    logic       oe_n;
    logic       fd;
  } outs_t;

  typedef struct {
    int         n;
    logic [6:0] v;   // {sclk, lat, oe_n, frame_done, row_addr}
  } cp_t;

  localparam outs_t RST_VAL = '{fb_addr: 8'd0, top: 3'd0, bot: 3'd0, row_addr: 3'd0,
                                sclk: 1'b0, lat: 1'b0, oe_n: 1'b1, fd: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] fb_rgb_top = '0;
  logic [2:0] fb_rgb_bot = '0;
  logic [7:0] fb_addr;
  logic       r1, g1, b1, r2, g2, b2;
  logic [2:0] row_addr;
  logic       sclk, lat, oe_n, frame_done;

  always #5 clk = ~clk;

  hub75_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .fb_addr    (fb_addr),
    .fb_rgb_top (fb_rgb_top),
    .fb_rgb_bot (fb_rgb_bot),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .r2         (r2),
    .g2         (g2),
    .b2         (b2),
    .row_addr   (row_addr),
    .sclk       (sclk),
    .lat        (lat),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  function automatic logic [2:0] pix_top(input int row, input int col);
    return 3'(col % 8);
  endfunction

  function automatic logic [2:0] pix_bot(input int row, input int col);
    return 3'(col % 8) ^ 3'(row) ^ 3'b101;
  endfunction

  // Frame buffer: data for the current address settles half a clock after it changes.
  always @(negedge clk) begin
    fb_rgb_top = pix_top(int'(fb_addr[7:5]), int'(fb_addr[4:0]));
    fb_rgb_bot = pix_bot(int'(fb_addr[7:5]), int'(fb_addr[4:0]));
  end

  int    errors = 0;
  int    checks = 0;
  int    n;
  outs_t sb_q[$];
  cp_t   cp[NCP];
  bit    main_run;
  int    cp_hits;
  int    rises_row0;
  int    oe_hi_row1;
  int    fd_q[$];
  logic  prev_sclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic outs_t dut_outs();
    return {fb_addr, r1, g1, b1, r2, g2, b2, row_addr, sclk, lat, oe_n, frame_done};
  endfunction

  function automatic logic [6:0] mk(input logic s, input logic l, input logic o,
                                    input logic f, input int ra);
    return {s, l, o, f, 3'(ra)};
  endfunction

  // Expected panel outputs right after tick n (n counted from the last reset).
  function automatic outs_t model(input int n_i);
    outs_t o;
    int r, t, k, prev;
    bit first;
    r     = (n_i / P) % R;
    t     = n_i % P;
    first = (n_i < P);
    prev  = first ? 0 : (r + R - 1) % R;
    o          = RST_VAL;
    o.row_addr = 3'(prev);
    o.fb_addr  = {3'((r + 1) % R), 5'd0};
    o.top      = pix_top(r, C - 1);
    o.bot      = pix_bot(r, C - 1);
    if (t < 2*C) begin
      k      = t / 2;
      o.sclk = (t % 2 == 1);
      o.top  = pix_top(r, k);
      o.bot  = pix_bot(r, k);
      o.oe_n = first;
      if (t % 2 == 0)   o.fb_addr = {3'(r), 5'(k)};
      else if (k < C-1) o.fb_addr = {3'(r), 5'(k + 1)};
    end else if (t == LAT_T) begin
      o.lat      = 1'b1;
      o.row_addr = 3'(r);
      o.fd       = (r == R - 1);
    end else if (t > LAT_T) begin
      o.oe_n     = 1'b0;
      o.row_addr = 3'(r);
    end
    return o;
  endfunction

  task automatic cycle(input logic t_v, input logic r_v);
    tick = t_v;
    rst  = r_v;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_tick();
    outs_t exp, hold, got;
    sb_q.push_back(model(n));
    cycle(1'b1, 1'b0);
    exp = sb_q.pop_front();
    got = dut_outs();
    check($sformatf("tick%0d", n), got, exp);
    if (main_run) begin
      for (int i = 0; i < NCP; i++) begin
        if (cp[i].n == n) begin
          cp_hits++;
          check($sformatf("checkpoint%0d_n%0d", i, n), {sclk, lat, oe_n, frame_done, row_addr}, cp[i].v);
        end
      end
      if (n < P && !prev_sclk && sclk) rises_row0++;
      if (n >= P && n < 2*P && oe_n) oe_hi_row1++;
      if (frame_done) fd_q.push_back(n);
      prev_sclk = sclk;
    end
    cycle(1'b0, 1'b0);
    hold    = exp;
    hold.fd = 1'b0;
    check($sformatf("hold%0d", n), dut_outs(), hold);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    n++;
  endtask

  initial begin
    cp[0]  = '{0,               mk(0, 0, 1, 0, 0)};
    cp[1]  = '{1,               mk(1, 0, 1, 0, 0)};
    cp[2]  = '{2*C - 1,         mk(1, 0, 1, 0, 0)};
    cp[3]  = '{2*C,             mk(0, 0, 1, 0, 0)};
    cp[4]  = '{LAT_T,           mk(0, 1, 1, 0, 0)};
    cp[5]  = '{LAT_T + 1,       mk(0, 0, 0, 0, 0)};
    cp[6]  = '{P - 1,           mk(0, 0, 0, 0, 0)};
    cp[7]  = '{P,               mk(0, 0, 0, 0, 0)};
    cp[8]  = '{P + 1,           mk(1, 0, 0, 0, 0)};
    cp[9]  = '{P + LAT_T,       mk(0, 1, 1, 0, 1)};
    cp[10] = '{7*P + LAT_T,     mk(0, 1, 1, 1, 7)};
    cp[11] = '{8*P + LAT_T,     mk(0, 1, 1, 0, 0)};
    cp[12] = '{15*P + LAT_T,    mk(0, 1, 1, 1, 7)};
    cp[13] = '{15*P + LAT_T + 1, mk(0, 0, 0, 0, 7)};
    cp[14] = '{16*P + 1,        mk(1, 0, 0, 0, 7)};

    main_run   = 1'b0;
    cp_hits    = 0;
    rises_row0 = 0;
    oe_hi_row1 = 0;
    prev_sclk  = 1'b0;

    @(posedge clk);
    #1;
    // Reset held 3 clocks, with a tick landing in the middle that must be ignored.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check("reset_values", dut_outs(), RST_VAL);
    cycle(1'b0, 1'b0);
    check("reset_idle_hold", dut_outs(), RST_VAL);

    // Scan into row 5 and stop at column 17.
    n = 0;
    repeat (5*P + 2*17) do_tick();

    // Mid-operation reset coincident with a tick.
    cycle(1'b1, 1'b1);
    check("mid_reset_values", dut_outs(), RST_VAL);
    cycle(1'b0, 1'b0);
    check("mid_reset_hold", dut_outs(), RST_VAL);
    check("restart_fb_addr", fb_addr, 8'd0);

    // Two full frames from a clean restart, with checkpoints and frame statistics.
    n        = 0;
    main_run = 1'b1;
    repeat (16*P + 10) do_tick();

    check("sclk_rises_row0", rises_row0, C);
    check("oe_n_high_ticks_row1", oe_hi_row1, BL + 1);
    check("checkpoints_reached", cp_hits, NCP);
    check("frame_done_count", fd_q.size(), 2);
    if (fd_q.size() >= 2) begin
      check("frame_done_first", fd_q[0], 7*P + LAT_T);
      check("frame_done_spacing", fd_q[1] - fd_q[0], 8*P);
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
